// File: rtl/int_seq_pkg.sv
// Shared types and widths for the interrupt entry / RTI return sequencer.
package int_seq_pkg;

   localparam int FLAG_W  = 3;
   localparam int STACK_W = 16;

   typedef enum logic [3:0] {
      S_IDLE,
      S_DRAIN,
      S_PUSH_PC_HI,
      S_PUSH_PC_LO,
      S_PUSH_FLAGS,
      S_VECTOR,
      S_POP_FLAGS,
      S_POP_PC_LO,
      S_POP_PC_HI,
      S_RESUME
   } state_e;

endpackage

// File: rtl/int_pending_latch.sv
// Sticky request latch; clear wins so the request being accepted is not re-serviced.
module int_pending_latch (
   input  logic clk,
   input  logic reset,
   input  logic set_i,
   input  logic clr_i,
   output logic pending_o
);

   logic pending_q;

   always_ff @(posedge clk) begin
      if (reset)      pending_q <= 1'b0;
      else if (clr_i) pending_q <= 1'b0;
      else if (set_i) pending_q <= 1'b1;
   end

   assign pending_o = pending_q;

endmodule

// File: rtl/int_sequencer.sv
// Sequences interrupt entry (drain, push PC/flags, vector) and RTI return
// (pop flags/PC, reload) around the execute stage.
//
// state       | meaning
// IDLE        | pipeline running, waiting for RTI or interrupt
// DRAIN       | stall while in-flight instructions retire
// PUSH_PC_HI  | push saved_pc upper half
// PUSH_PC_LO  | push saved_pc lower half
// PUSH_FLAGS  | push saved flags
// VECTOR      | load interrupt vector, acknowledge
// POP_FLAGS   | pop flags, restore next cycle
// POP_PC_LO   | pop PC lower half
// POP_PC_HI   | pop PC upper half
// RESUME      | load restored PC
module int_sequencer
   import int_seq_pkg::*;
#(
   parameter int          PC_W         = 32,
   parameter int          DRAIN_CYCLES = 3,
   parameter logic [31:0] INT_VECTOR   = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                int_req,
   input  logic                rti_valid,
   input  logic [PC_W-1:0]     pc_in,
   input  logic [FLAG_W-1:0]   flags_in,
   output logic                stall,
   output logic                flush,
   output logic                stack_req,
   output logic                stack_push,
   output logic [STACK_W-1:0]  stack_wdata,
   input  logic [STACK_W-1:0]  stack_rdata,
   input  logic                stack_ack,
   output logic                pc_load,
   output logic [PC_W-1:0]     pc_out,
   output logic                flags_load,
   output logic [FLAG_W-1:0]   flags_out,
   output logic                int_ack,
   output logic                busy
);

   localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [PC_W-1:0]     saved_pc_q, saved_pc_d;
   logic [FLAG_W-1:0]   saved_flags_q, saved_flags_d;
   logic [STACK_W-1:0]  lo_q, lo_d;
   logic [PC_W-1:0]     pc_out_q, pc_out_d;
   logic [FLAG_W-1:0]   flags_out_q, flags_out_d;
   logic                flags_load_q, flags_load_d;
   logic                pending, pend_clr;

   int_pending_latch u_pending (
      .clk       (clk),
      .reset     (reset),
      .set_i     (int_req),
      .clr_i     (pend_clr),
      .pending_o (pending)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         saved_pc_q    <= '0;
         saved_flags_q <= '0;
         lo_q          <= '0;
         pc_out_q      <= '0;
         flags_out_q   <= '0;
         flags_load_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         saved_pc_q    <= saved_pc_d;
         saved_flags_q <= saved_flags_d;
         lo_q          <= lo_d;
         pc_out_q      <= pc_out_d;
         flags_out_q   <= flags_out_d;
         flags_load_q  <= flags_load_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      saved_pc_d    = saved_pc_q;
      saved_flags_d = saved_flags_q;
      lo_d          = lo_q;
      pc_out_d      = pc_out_q;
      flags_out_d   = flags_out_q;
      flags_load_d  = 1'b0;
      pend_clr      = 1'b0;
      stall         = 1'b1;
      flush         = 1'b0;
      stack_req     = 1'b0;
      stack_push    = 1'b0;
      stack_wdata   = '0;
      pc_load       = 1'b0;
      int_ack       = 1'b0;

      case (state_q)
         S_IDLE: begin
            stall = 1'b0;
            if (rti_valid) begin
               state_d = S_POP_FLAGS;
            end else if (pending || int_req) begin
               saved_pc_d = pc_in;
               cnt_d      = CNT_INIT;
               pend_clr   = 1'b1;
               state_d    = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // counter is loaded with its start value on entry, so this marks cycle one
            flush = (cnt_q == CNT_INIT);
            if (cnt_q == '0) begin
               saved_flags_d = flags_in;
               state_d       = S_PUSH_PC_HI;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_PUSH_PC_HI: begin
            stack_req   = 1'b1;
            stack_push  = 1'b1;
            stack_wdata = STACK_W'(saved_pc_q[PC_W-1:16]);
            if (stack_ack) state_d = S_PUSH_PC_LO;
         end
         S_PUSH_PC_LO: begin
            stack_req   = 1'b1;
            stack_push  = 1'b1;
            stack_wdata = saved_pc_q[15:0];
            if (stack_ack) state_d = S_PUSH_FLAGS;
         end
         S_PUSH_FLAGS: begin
            stack_req   = 1'b1;
            stack_push  = 1'b1;
            stack_wdata = {{(STACK_W-FLAG_W){1'b0}}, saved_flags_q};
            if (stack_ack) begin
               pc_out_d = PC_W'(INT_VECTOR);
               state_d  = S_VECTOR;
            end
         end
         S_VECTOR: begin
            pc_load = 1'b1;
            int_ack = 1'b1;
            state_d = S_IDLE;
         end
         S_POP_FLAGS: begin
            stack_req = 1'b1;
            if (stack_ack) begin
               flags_out_d  = stack_rdata[FLAG_W-1:0];
               flags_load_d = 1'b1;
               state_d      = S_POP_PC_LO;
            end
         end
         S_POP_PC_LO: begin
            stack_req = 1'b1;
            if (stack_ack) begin
               lo_d    = stack_rdata;
               state_d = S_POP_PC_HI;
            end
         end
         S_POP_PC_HI: begin
            stack_req = 1'b1;
            if (stack_ack) begin
               pc_out_d = {stack_rdata[PC_W-17:0], lo_q};
               state_d  = S_RESUME;
            end
         end
         S_RESUME: begin
            pc_load = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign pc_out     = pc_out_q;
   assign flags_out  = flags_out_q;
   assign flags_load = flags_load_q;
   assign busy       = stall;

endmodule
